// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - size encodings (same as the CPU store-size select)
//   - FSM state type for the responder
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for the data-memory responder (purely combinational).
// Ports:
//   i_size        access size (word/half/byte/illegal)
//   i_addr_lo     byte offset within the word
//   i_wdata       right-justified store data
//   i_rword       word currently stored at the addressed index
//   o_be          per-lane write enable
//   o_wdata_lanes store data replicated onto every candidate lane
//   o_misalign    half/word not naturally aligned
//   o_rdata       addressed lane(s), right-justified and zero-extended
module dmem_lane_ctrl
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_lanes,
    output logic        o_misalign,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shifted;

    // Addressed byte ends up in [7:0].
    assign w_shifted = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be          = 4'b0000;
        o_wdata_lanes = i_wdata;
        o_misalign    = 1'b0;
        o_rdata       = 32'h0;
        case (i_size)
            SZ_WORD: begin
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
                o_rdata    = i_rword;
            end
            SZ_HALF: begin
                o_be          = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_lanes = {2{i_wdata[15:0]}};
                o_misalign    = i_addr_lo[0];
                o_rdata       = {16'h0, i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0]};
            end
            SZ_BYTE: begin
                o_be          = 4'b0001 << i_addr_lo;
                o_wdata_lanes = {4{i_wdata[7:0]}};
                o_rdata       = {24'h0, w_shifted[7:0]};
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: one request at a time,
// WAIT_CYCLES wait states, then a one-cycle ready pulse with rdata/err.
// Ports:
//   i_clk, i_reset (async, active-high)
//   i_req, i_we, i_addr, i_size, i_wdata   request (sampled only in idle)
//   o_ready  one-cycle response pulse
//   o_rdata  load result, holds between responses
//   o_err    error qualifier, meaningful only with o_ready
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic        NO_WAIT   = (WAIT_CYCLES == 0);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic [31:0] r_wdata;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_live;
    logic          w_we;
    logic [31:0]   w_addr;
    logic [1:0]    w_size;
    logic [31:0]   w_wdata;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rword;
    logic [3:0]    w_be;
    logic [31:0]   w_wlanes;
    logic          w_misalign;
    logic [31:0]   w_load;
    logic          w_err;
    logic          w_commit;

    // With no wait states the commit edge is the accepting edge, so the
    // live request is used there; otherwise the captured copy.
    assign w_live  = (r_state == StIdle);
    assign w_we    = w_live ? i_we    : r_we;
    assign w_addr  = w_live ? i_addr  : r_addr;
    assign w_size  = w_live ? i_size  : r_size;
    assign w_wdata = w_live ? i_wdata : r_wdata;

    assign w_idx   = w_addr[AW+1:2];
    assign w_rword = r_mem[w_idx];

    dmem_lane_ctrl u_lane_ctrl (
        .i_size        (w_size),
        .i_addr_lo     (w_addr[1:0]),
        .i_wdata       (w_wdata),
        .i_rword       (w_rword),
        .o_be          (w_be),
        .o_wdata_lanes (w_wlanes),
        .o_misalign    (w_misalign),
        .o_rdata       (w_load)
    );

    assign w_err = w_misalign || (w_size == SZ_ILL) || (w_addr[31:2] >= 30'(DEPTH_WORDS));

    // Edge entering RESP; gated by reset so a held reset can never commit.
    assign w_commit = !i_reset &&
                      (((r_state == StIdle) && i_req && NO_WAIT) ||
                       ((r_state == StWait) && (r_cnt == 4'd0)));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'h0;
            r_size  <= SZ_WORD;
            r_wdata <= 32'h0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            if (w_commit) begin
                r_ready <= 1'b1;
                r_err   <= w_err;
                if (!w_err && !w_we) begin
                    r_rdata <= w_load;
                end
            end
            case (r_state)
                StIdle: begin
                    if (i_req) begin
                        r_we    <= i_we;
                        r_addr  <= i_addr;
                        r_size  <= i_size;
                        r_wdata <= i_wdata;
                        if (NO_WAIT) begin
                            r_state <= StResp;
                        end else begin
                            r_state <= StWait;
                            r_cnt   <= WAIT_LOAD;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Word array: no reset, contents undefined until written.
    always_ff @(posedge i_clk) begin
        if (w_commit && !w_err && w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    assign o_ready = r_ready;
    assign o_err   = r_err;
    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus a random
// phase, checked against a byte-addressed reference model.
module tb_dmem_responder;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [1:0]  size = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic        ready, err, ready0, err0;
    logic [31:0] rdata, rdata0;

    int total = 0;
    int bad = 0;

    logic [7:0]  m [0:1023];
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(W)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
        .i_size(size), .i_wdata(wdata), .o_ready(ready), .o_rdata(rdata), .o_err(err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
        .i_size(size), .i_wdata(wdata), .o_ready(ready0), .o_rdata(rdata0), .o_err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd0 && a[1:0] != 2'd0) ||
               ((a >> 2) >= 32'd256);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    endfunction

    // One full transaction on the W-wait instance, checking latency and result.
    task automatic txn(input string tag, input logic w, input logic [31:0] a,
                       input logic [1:0] s, input logic [31:0] d);
        int  k;
        logic e;
        logic [31:0] v;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; size = s; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        k = 0;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_lat"}, k, W);
        e = ref_err(a, s);
        if (!e) begin
            if (w) begin
                for (int i = 0; i < nbytes(s); i++) m[a + i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < nbytes(s); i++) v[8*i +: 8] = m[a + i];
                exp_rdata = v;
            end
        end
        check({tag, "_err"}, {31'h0, err}, {31'h0, e});
        check({tag, "_rdata"}, rdata, exp_rdata);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'h0, ready}, 32'h0);
    endtask

    initial begin
        int e2 [$];
        int e0 [$];
        logic [31:0] a;
        #2;
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;

        // 1-3: lane placement
        txn("t1_sw", 1, 32'h10, 2'd0, 32'hDEADBEEF);
        txn("t1_lw", 0, 32'h10, 2'd0, 32'h0);
        check("t1_val", rdata, 32'hDEADBEEF);
        txn("t2_sb", 1, 32'h11, 2'd2, 32'h000000AB);
        txn("t2_lw", 0, 32'h10, 2'd0, 32'h0);
        check("t2_val", rdata, 32'hDEADABEF);
        txn("t2_lb", 0, 32'h11, 2'd2, 32'h0);
        check("t2_lbv", rdata, 32'h000000AB);
        txn("t2_lh", 0, 32'h12, 2'd1, 32'h0);
        check("t2_lhv", rdata, 32'h0000DEAD);
        txn("t3_sh", 1, 32'h12, 2'd1, 32'h00001234);
        txn("t3_lw", 0, 32'h10, 2'd0, 32'h0);
        check("t3_val", rdata, 32'h1234ABEF);
        txn("t3_lh13", 0, 32'h13, 2'd1, 32'h0);
        check("t3_hold", rdata, 32'h1234ABEF);

        // 4: errors leave word 0 alone
        txn("t4_init", 1, 32'h00, 2'd0, 32'h5A5A1234);
        txn("t4_oob", 0, 32'h400, 2'd0, 32'h0);
        txn("t4_sz3", 1, 32'h00, 2'd3, 32'hFFFFFFFF);
        txn("t4_mis", 1, 32'h02, 2'd0, 32'hFFFFFFFF);
        txn("t4_lw", 0, 32'h00, 2'd0, 32'h0);
        check("t4_val", rdata, 32'h5A5A1234);

        // 5: reset during WAIT drops the store
        txn("t5_sw", 1, 32'h20, 2'd0, 32'h00000000);
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; size = 2'd0; wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t5_ready", {31'h0, ready}, 32'h0);
        check("t5_err", {31'h0, err}, 32'h0);
        check("t5_rdata", rdata, 32'h0);
        exp_rdata = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
            check("t5_noresp", {31'h0, ready}, 32'h0);
        end
        @(negedge clk); reset = 1'b0;
        txn("t5_lw", 0, 32'h20, 2'd0, 32'h0);
        check("t5_val", rdata, 32'h0);

        // random phase over a pre-written window, with occasional bad addresses
        for (int i = 0; i < 16; i++) txn("rnd_init", 1, 32'h40 + 32'(4 * i), 2'd0, $urandom);
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h400 + $urandom_range(0, 255)
                                             : 32'h40 + $urandom_range(0, 63);
            txn("rnd", 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom);
        end

        // 6: back-to-back throughput for both wait settings
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h40; size = 2'd0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (ready)  e2.push_back(c);
            if (ready0) e0.push_back(c);
        end
        req = 1'b0;
        check("t6_n2", e2.size(), 5);
        check("t6_n0", e0.size(), 10);
        if (e2.size() > 0) check("t6_first2", e2[0], 3);
        if (e0.size() > 0) check("t6_first0", e0[0], 1);
        for (int i = 1; i < e2.size(); i++) check("t6_gap2", e2[i] - e2[i-1], 4);
        for (int i = 1; i < e0.size(); i++) check("t6_gap0", e0[i] - e0[i-1], 2);

        repeat (6) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
